// File: rtl/mips_pkg.sv
// Shared widths, register-zero constant, write-back entry type and ALU buffer
// state encoding for the write-back scheduler.
package mips_pkg;

  localparam int AW_DEF     = 5;
  localparam int DATA_W_DEF = 32;
  localparam int REG_ZERO   = 0;

  typedef struct packed {
    logic [AW_DEF-1:0]     rd;
    logic [DATA_W_DEF-1:0] data;
  } wb_entry;

  localparam logic [1:0] FIFO_EMPTY = 2'd0;
  localparam logic [1:0] FIFO_ONE   = 2'd1;
  localparam logic [1:0] FIFO_FULL  = 2'd2;

endpackage

// File: rtl/regfile_wb_scheduler_wb_fifo.sv
// Two-entry in-order buffer for ALU write-backs that lost arbitration.
// Slot 0 is always the head; a dequeue shifts slot 1 forward.
module wb_fifo
  import mips_pkg::*;
#(
  parameter int AW     = AW_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              arst_n,
  input  logic              enq,
  input  logic [AW-1:0]     enq_rd,
  input  logic [DATA_W-1:0] enq_data,
  input  logic              deq,
  output logic [1:0]        state,
  output logic [AW-1:0]     head_rd,
  output logic [DATA_W-1:0] head_data
);

  logic [1:0]        state_r;
  logic [1:0]        state_nxt_s;
  logic [AW-1:0]     rd0_r;
  logic [AW-1:0]     rd1_r;
  logic [DATA_W-1:0] data0_r;
  logic [DATA_W-1:0] data1_r;

  // Occupancy transitions; enqueue while FULL is excluded by the ready handshake.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      FIFO_EMPTY: begin
        if (enq) state_nxt_s = FIFO_ONE;
        else     state_nxt_s = FIFO_EMPTY;
      end
      FIFO_ONE: begin
        if (enq && !deq)      state_nxt_s = FIFO_FULL;
        else if (!enq && deq) state_nxt_s = FIFO_EMPTY;
        else                  state_nxt_s = FIFO_ONE;
      end
      FIFO_FULL: begin
        if (deq) state_nxt_s = FIFO_ONE;
        else     state_nxt_s = FIFO_FULL;
      end
      default: state_nxt_s = FIFO_EMPTY;
    endcase
  end

  // Occupancy register.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) state_r <= FIFO_EMPTY;
    else         state_r <= state_nxt_s;
  end

  // Entry storage: shift on dequeue, fill the first free slot on enqueue.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      rd0_r   <= '0;
      rd1_r   <= '0;
      data0_r <= '0;
      data1_r <= '0;
    end else if (deq) begin
      if (state_r == FIFO_FULL) begin
        rd0_r   <= rd1_r;
        data0_r <= data1_r;
      end else if (enq) begin
        rd0_r   <= enq_rd;
        data0_r <= enq_data;
      end
    end else if (enq) begin
      if (state_r == FIFO_EMPTY) begin
        rd0_r   <= enq_rd;
        data0_r <= enq_data;
      end else begin
        rd1_r   <= enq_rd;
        data1_r <= enq_data;
      end
    end
  end

  assign state     = state_r;
  assign head_rd   = rd0_r;
  assign head_data = data0_r;

endmodule

// File: rtl/regfile_wb_scheduler.sv
// Write-back scheduler: merges load and ALU results onto one registered
// register-file write port and keeps the issue scoreboard.
module regfile_wb_scheduler
  import mips_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int AW     = AW_DEF
) (
  input  logic              clk,
  input  logic              arst_n,
  input  logic              issue_valid,
  input  logic [AW-1:0]     issue_rs,
  input  logic [AW-1:0]     issue_rt,
  input  logic [AW-1:0]     issue_dst,
  input  logic              issue_wr,
  output logic              issue_stall,
  input  logic              mem_wb_valid,
  input  logic [AW-1:0]     mem_wb_rd,
  input  logic [DATA_W-1:0] mem_wb_data,
  input  logic              alu_wb_valid,
  input  logic [AW-1:0]     alu_wb_rd,
  input  logic [DATA_W-1:0] alu_wb_data,
  output logic              alu_wb_ready,
  output logic              RegWr,
  output logic [AW-1:0]     Rd,
  output logic [DATA_W-1:0] busW,
  output logic [2**AW-1:0]  pending
);

  localparam int NREG = 2**AW;

  logic [NREG-1:0]   pending_r;
  logic [NREG-1:0]   pending_nxt_s;
  logic [NREG-1:0]   set_vec_s;
  logic [NREG-1:0]   clr_vec_s;
  logic              reg_wr_r;
  logic [AW-1:0]     rd_r;
  logic [DATA_W-1:0] bus_w_r;

  logic              mem_ok_s;
  logic              alu_ok_s;
  logic              win_s;
  logic [AW-1:0]     win_rd_s;
  logic [DATA_W-1:0] win_data_s;
  logic              fifo_enq_s;
  logic              fifo_deq_s;
  logic [1:0]        fifo_state_s;
  logic [AW-1:0]     head_rd_s;
  logic [DATA_W-1:0] head_data_s;

  wb_fifo #(.AW(AW), .DATA_W(DATA_W)) u_fifo (
    .clk       (clk),
    .arst_n    (arst_n),
    .enq       (fifo_enq_s),
    .enq_rd    (alu_wb_rd),
    .enq_data  (alu_wb_data),
    .deq       (fifo_deq_s),
    .state     (fifo_state_s),
    .head_rd   (head_rd_s),
    .head_data (head_data_s)
  );

  // Register-0 write-backs are accepted but never take a slot.
  assign mem_ok_s     = mem_wb_valid && (mem_wb_rd != AW'(REG_ZERO));
  assign alu_wb_ready = (fifo_state_s != FIFO_FULL);
  assign alu_ok_s     = alu_wb_valid && alu_wb_ready && (alu_wb_rd != AW'(REG_ZERO));

  assign issue_stall = issue_valid &&
                       (pending_r[issue_rs] || pending_r[issue_rt] ||
                        (issue_wr && pending_r[issue_dst]));

  // Fixed-priority arbitration: load, then buffered ALU head, then direct ALU.
  always_comb begin
    win_s      = 1'b0;
    win_rd_s   = mem_wb_rd;
    win_data_s = mem_wb_data;
    fifo_enq_s = 1'b0;
    fifo_deq_s = 1'b0;
    if (mem_ok_s) begin
      win_s      = 1'b1;
      fifo_enq_s = alu_ok_s;
    end else if (fifo_state_s != FIFO_EMPTY) begin
      win_s      = 1'b1;
      win_rd_s   = head_rd_s;
      win_data_s = head_data_s;
      fifo_deq_s = 1'b1;
      fifo_enq_s = alu_ok_s;
    end else if (alu_ok_s) begin
      win_s      = 1'b1;
      win_rd_s   = alu_wb_rd;
      win_data_s = alu_wb_data;
    end else begin
      win_s      = 1'b0;
    end
  end

  // Registered write port; address and data hold while idle.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      reg_wr_r <= 1'b0;
      rd_r     <= '0;
      bus_w_r  <= '0;
    end else begin
      reg_wr_r <= win_s;
      if (win_s) begin
        rd_r    <= win_rd_s;
        bus_w_r <= win_data_s;
      end
    end
  end

  // Scoreboard update: clear on the edge the register file captures the write.
  always_comb begin
    set_vec_s = '0;
    clr_vec_s = '0;
    if (issue_valid && !issue_stall && issue_wr && (issue_dst != AW'(REG_ZERO)))
      set_vec_s[issue_dst] = 1'b1;
    else
      set_vec_s = '0;
    if (reg_wr_r)
      clr_vec_s[rd_r] = 1'b1;
    else
      clr_vec_s = '0;
    pending_nxt_s    = (pending_r & ~clr_vec_s) | set_vec_s;
    pending_nxt_s[0] = 1'b0;
  end

  // Scoreboard register.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) pending_r <= '0;
    else         pending_r <= pending_nxt_s;
  end

  assign RegWr   = reg_wr_r;
  assign Rd      = rd_r;
  assign busW    = bus_w_r;
  assign pending = pending_r;

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Directed bench for regfile_wb_scheduler: expected commits are queued by the
// stimulus and consumed by an independent write-port monitor.
module tb_regfile_wb_scheduler;
  import mips_pkg::*;

  logic        clk;
  logic        arst_n;
  logic        issue_valid;
  logic [4:0]  issue_rs;
  logic [4:0]  issue_rt;
  logic [4:0]  issue_dst;
  logic        issue_wr;
  logic        issue_stall;
  logic        mem_wb_valid;
  logic [4:0]  mem_wb_rd;
  logic [31:0] mem_wb_data;
  logic        alu_wb_valid;
  logic [4:0]  alu_wb_rd;
  logic [31:0] alu_wb_data;
  logic        alu_wb_ready;
  logic        RegWr;
  logic [4:0]  Rd;
  logic [31:0] busW;
  logic [31:0] pending;

  int pass_cnt = 0;
  int chk_cnt  = 0;
  wb_entry exp_q[$];

  regfile_wb_scheduler #(.DATA_W(32), .AW(5)) dut (
    .clk          (clk),
    .arst_n       (arst_n),
    .issue_valid  (issue_valid),
    .issue_rs     (issue_rs),
    .issue_rt     (issue_rt),
    .issue_dst    (issue_dst),
    .issue_wr     (issue_wr),
    .issue_stall  (issue_stall),
    .mem_wb_valid (mem_wb_valid),
    .mem_wb_rd    (mem_wb_rd),
    .mem_wb_data  (mem_wb_data),
    .alu_wb_valid (alu_wb_valid),
    .alu_wb_rd    (alu_wb_rd),
    .alu_wb_data  (alu_wb_data),
    .alu_wb_ready (alu_wb_ready),
    .RegWr        (RegWr),
    .Rd           (Rd),
    .busW         (busW),
    .pending      (pending)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [4:0] rd, input logic [31:0] data);
    wb_entry e;
    e.rd   = rd;
    e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic idle_inputs();
    issue_valid  = 1'b0;
    issue_rs     = 5'd0;
    issue_rt     = 5'd0;
    issue_dst    = 5'd0;
    issue_wr     = 1'b0;
    mem_wb_valid = 1'b0;
    mem_wb_rd    = 5'd0;
    mem_wb_data  = 32'd0;
    alu_wb_valid = 1'b0;
    alu_wb_rd    = 5'd0;
    alu_wb_data  = 32'd0;
  endtask

  task automatic set_mem(input logic v, input logic [4:0] rd, input logic [31:0] d);
    mem_wb_valid = v;
    mem_wb_rd    = rd;
    mem_wb_data  = d;
  endtask

  task automatic set_alu(input logic v, input logic [4:0] rd, input logic [31:0] d);
    alu_wb_valid = v;
    alu_wb_rd    = rd;
    alu_wb_data  = d;
  endtask

  task automatic set_issue(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                           input logic [4:0] dst, input logic wr);
    issue_valid = v;
    issue_rs    = rs;
    issue_rt    = rt;
    issue_dst   = dst;
    issue_wr    = wr;
  endtask

  // Write-port monitor: every commit must match the head of the expected queue.
  always @(negedge clk) begin
    if (arst_n && RegWr) begin
      if (exp_q.size() == 0) begin
        chk_cnt++;
        $display("FAIL unexpected_commit: got rd=%0d data=%h expected no write", Rd, busW);
      end else begin
        wb_entry e;
        e = exp_q.pop_front();
        check("commit", {27'd0, Rd, busW}, {27'd0, e.rd, e.data});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    idle_inputs();
    arst_n = 1'b0;
    #2;
    check("reset_regwr", {63'd0, RegWr}, 64'd0);
    check("reset_rd_busw", {27'd0, Rd, busW}, 64'd0);
    check("reset_pending", {32'd0, pending}, 64'd0);
    check("reset_ready", {63'd0, alu_wb_ready}, 64'd1);
    #10 arst_n = 1'b1;
    tick();

    // RAW stall held until the commit edge of r3
    set_issue(1'b1, 5'd0, 5'd0, 5'd3, 1'b1);
    @(negedge clk);
    check("raw_first_accept", {63'd0, issue_stall}, 64'd0);
    tick();
    set_issue(1'b1, 5'd3, 5'd0, 5'd0, 1'b0);
    @(negedge clk);
    check("raw_stall", {63'd0, issue_stall}, 64'd1);
    check("raw_pending", {32'd0, pending}, 64'h8);
    set_mem(1'b1, 5'd3, 32'h0000_0033);
    push(5'd3, 32'h0000_0033);
    tick();
    set_mem(1'b0, 5'd0, 32'd0);
    @(negedge clk);
    check("raw_stall_during_commit", {63'd0, issue_stall}, 64'd1);
    tick();
    @(negedge clk);
    check("raw_released", {63'd0, issue_stall}, 64'd0);
    tick();
    idle_inputs();

    // Simultaneous load and ALU write-back
    set_mem(1'b1, 5'd5, 32'hAAAA_0001);
    set_alu(1'b1, 5'd6, 32'h0000_0001);
    push(5'd5, 32'hAAAA_0001);
    push(5'd6, 32'h0000_0001);
    @(negedge clk);
    check("sim_ready_c0", {63'd0, alu_wb_ready}, 64'd1);
    tick();
    idle_inputs();
    @(negedge clk);
    check("sim_ready_c1", {63'd0, alu_wb_ready}, 64'd1);
    tick();
    tick();

    // Load held three cycles while ALU streams r7,r8,r9
    push(5'd10, 32'h1000_000A);
    push(5'd11, 32'h1000_000B);
    push(5'd12, 32'h1000_000C);
    push(5'd7,  32'h0000_0070);
    push(5'd8,  32'h0000_0080);
    push(5'd9,  32'h0000_0090);
    set_mem(1'b1, 5'd10, 32'h1000_000A);
    set_alu(1'b1, 5'd7, 32'h0000_0070);
    @(negedge clk);
    check("stream_ready_c1", {63'd0, alu_wb_ready}, 64'd1);
    tick();
    set_mem(1'b1, 5'd11, 32'h1000_000B);
    set_alu(1'b1, 5'd8, 32'h0000_0080);
    @(negedge clk);
    check("stream_ready_c2", {63'd0, alu_wb_ready}, 64'd1);
    tick();
    set_mem(1'b1, 5'd12, 32'h1000_000C);
    set_alu(1'b1, 5'd9, 32'h0000_0090);
    @(negedge clk);
    check("stream_ready_c3_full", {63'd0, alu_wb_ready}, 64'd0);
    tick();
    set_mem(1'b0, 5'd0, 32'd0);
    @(negedge clk);
    check("stream_ready_c4_full", {63'd0, alu_wb_ready}, 64'd0);
    tick();
    @(negedge clk);
    check("stream_ready_c5", {63'd0, alu_wb_ready}, 64'd1);
    tick();
    idle_inputs();
    tick();
    tick();

    // Register-0 ALU write-back is discarded
    set_issue(1'b1, 5'd0, 5'd0, 5'd9, 1'b1);
    tick();
    idle_inputs();
    set_alu(1'b1, 5'd0, 32'hFFFF_FFFF);
    @(negedge clk);
    check("r0_ready", {63'd0, alu_wb_ready}, 64'd1);
    tick();
    idle_inputs();
    @(negedge clk);
    check("r0_no_write", {63'd0, RegWr}, 64'd0);
    check("r0_pending", {32'd0, pending}, 64'h200);
    tick();
    @(negedge clk);
    check("r0_no_write_late", {63'd0, RegWr}, 64'd0);
    set_mem(1'b1, 5'd9, 32'h0000_0099);
    push(5'd9, 32'h0000_0099);
    tick();
    idle_inputs();
    tick();
    @(negedge clk);
    check("r0_pending_cleared", {32'd0, pending}, 64'd0);

    // Reads of r0 never stall; WAW on a pending destination does
    set_issue(1'b1, 5'd0, 5'd0, 5'd4, 1'b1);
    tick();
    set_issue(1'b1, 5'd0, 5'd0, 5'd0, 1'b0);
    @(negedge clk);
    check("r0_read_no_stall", {63'd0, issue_stall}, 64'd0);
    tick();
    set_issue(1'b1, 5'd0, 5'd0, 5'd4, 1'b1);
    @(negedge clk);
    check("waw_stall", {63'd0, issue_stall}, 64'd1);
    tick();
    idle_inputs();
    set_mem(1'b1, 5'd4, 32'h0000_0044);
    push(5'd4, 32'h0000_0044);
    tick();
    idle_inputs();
    tick();

    // Reset with a full buffer and r7/r8 pending
    set_issue(1'b1, 5'd0, 5'd0, 5'd7, 1'b1);
    tick();
    set_issue(1'b1, 5'd0, 5'd0, 5'd8, 1'b1);
    tick();
    idle_inputs();
    set_mem(1'b1, 5'd10, 32'h0000_00A0);
    set_alu(1'b1, 5'd11, 32'h0000_00B0);
    push(5'd10, 32'h0000_00A0);
    tick();
    set_mem(1'b1, 5'd12, 32'h0000_00C0);
    set_alu(1'b1, 5'd13, 32'h0000_00D0);
    push(5'd12, 32'h0000_00C0);
    tick();
    idle_inputs();
    @(negedge clk);
    check("rst_pre_full", {63'd0, alu_wb_ready}, 64'd0);
    check("rst_pre_pending", {32'd0, pending}, 64'h180);
    #2 arst_n = 1'b0;
    #1;
    check("rst_mid_pending", {32'd0, pending}, 64'd0);
    check("rst_mid_regwr", {63'd0, RegWr}, 64'd0);
    check("rst_mid_rd_busw", {27'd0, Rd, busW}, 64'd0);
    check("rst_mid_ready", {63'd0, alu_wb_ready}, 64'd1);
    tick();
    #3 arst_n = 1'b1;
    tick();
    tick();
    tick();
    tick();
    set_issue(1'b1, 5'd7, 5'd8, 5'd0, 1'b0);
    @(negedge clk);
    check("post_rst_no_stall", {63'd0, issue_stall}, 64'd0);
    check("post_rst_regwr", {63'd0, RegWr}, 64'd0);
    check("post_rst_ready", {63'd0, alu_wb_ready}, 64'd1);
    tick();
    idle_inputs();
    tick();
    check("all_commits_seen", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
